// File: rtl/word_unpack_fsm.sv
// word_unpack_fsm: unpacks 16-bit words from an input RAM into byte pairs.
// Optional build macro WORD_UNPACK_BIG_ENDIAN_EN selects high byte first.

// Dual-port RAM: synchronous write, asynchronous read, no reset on contents.
module ram_dp_async_read #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

module word_unpack_fsm #(
  parameter int N_WORDS = 16,
  parameter int WAW     = 4,
  parameter int BAW     = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ram_in_we,
  input  logic [WAW-1:0] ram_in_addr_wr,
  input  logic [15:0]    ram_in_data_wr,
  input  logic [BAW-1:0] ram_out_addr_rd,
  output logic [7:0]     ram_out_data_rd,
  input  logic           start_in,
  output logic           busy_out,
  output logic           done_out
);

  typedef enum logic [1:0] {
    IDLE,
    READ_WORD,
    WRITE_LO,
    WRITE_HI
  } state_t;

  localparam logic [WAW-1:0] LAST = WAW'(N_WORDS - 1);

  state_t         state_q, state_d;
  logic [WAW-1:0] ptr_q, ptr_d;
  logic [15:0]    buf_q, buf_d;
  logic           done_q, done_d;

  logic           in_we;
  logic [15:0]    in_rdata;
  logic           out_we;
  logic [BAW-1:0] out_addr;
  logic [7:0]     out_data;
  logic [7:0]     even_byte;
  logic [7:0]     odd_byte;

  assign busy_out = (state_q != IDLE);
  assign done_out = done_q;

  // Host writes are dropped while a run is using the input RAM.
  assign in_we = ram_in_we & ~busy_out;

`ifdef WORD_UNPACK_BIG_ENDIAN_EN
  assign even_byte = buf_q[15:8];
  assign odd_byte  = buf_q[7:0];
`else
  assign even_byte = buf_q[7:0];
  assign odd_byte  = buf_q[15:8];
`endif

  ram_dp_async_read #(
    .AW(WAW),
    .DW(16)
  ) u_ram_in (
    .clk    (clk),
    .we_i   (in_we),
    .waddr_i(ram_in_addr_wr),
    .wdata_i(ram_in_data_wr),
    .raddr_i(ptr_q),
    .rdata_o(in_rdata)
  );

  ram_dp_async_read #(
    .AW(BAW),
    .DW(8)
  ) u_ram_out (
    .clk    (clk),
    .we_i   (out_we),
    .waddr_i(out_addr),
    .wdata_i(out_data),
    .raddr_i(ram_out_addr_rd),
    .rdata_o(ram_out_data_rd)
  );

  // State, pointer, word buffer and completion flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and output RAM write control.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    buf_d    = buf_q;
    done_d   = done_q;
    out_we   = 1'b0;
    out_addr = {ptr_q, 1'b0};
    out_data = even_byte;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          done_d  = 1'b0;
          ptr_d   = '0;
          state_d = READ_WORD;
        end
      end
      READ_WORD: begin
        buf_d   = in_rdata;
        state_d = WRITE_LO;
      end
      WRITE_LO: begin
        out_we   = 1'b1;
        out_addr = {ptr_q, 1'b0};
        out_data = even_byte;
        state_d  = WRITE_HI;
      end
      WRITE_HI: begin
        out_we   = 1'b1;
        out_addr = {ptr_q, 1'b1};
        out_data = odd_byte;
        if (ptr_q == LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = READ_WORD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_word_unpack_fsm.sv
// tb_word_unpack_fsm: directed and randomized checks of word_unpack_fsm
// against a word-array reference model.
module tb_word_unpack_fsm;

  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_in_we;
  logic [3:0]  ram_in_addr_wr;
  logic [15:0] ram_in_data_wr;
  logic [4:0]  ram_out_addr_rd;
  logic [7:0]  ram_out_data_rd;
  logic        start_in;
  logic        busy_out;
  logic        done_out;

  int passed = 0;
  int total  = 0;
  int lat;
  int bcnt;

  logic [15:0] mw [NW];

  always #5 clk = ~clk;

  word_unpack_fsm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ram_in_we      (ram_in_we),
    .ram_in_addr_wr (ram_in_addr_wr),
    .ram_in_data_wr (ram_in_data_wr),
    .ram_out_addr_rd(ram_out_addr_rd),
    .ram_out_data_rd(ram_out_data_rd),
    .start_in       (start_in),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int b);
    logic [15:0] w;
    int lo;
    w  = mw[b / 2];
`ifdef WORD_UNPACK_BIG_ENDIAN_EN
    lo = (b % 2) == 1;
`else
    lo = (b % 2) == 0;
`endif
    return lo ? 8'(w % 256) : 8'(w / 256);
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    ram_in_we      = 1'b1;
    ram_in_addr_wr = 4'(a);
    ram_in_data_wr = d;
    if (!busy_out) mw[a] = d;
    step();
    ram_in_we = 1'b0;
  endtask

  task automatic chk_bytes(input string tag);
    for (int b = 0; b < 2 * NW; b++) begin
      ram_out_addr_rd = 5'(b);
      #1;
      chk($sformatf("%s_b%0d", tag, b), 32'(ram_out_data_rd),
          32'(exp_byte(b)));
    end
  endtask

  // Counts edges after the start edge until done, and busy samples seen.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = busy_out ? 1 : 0;
    while (!done_out && n < 200) begin
      step();
      n++;
      if (busy_out) nb++;
    end
  endtask

  task automatic run(input string tag);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    wait_done(lat, bcnt);
    chk({tag, "_lat"}, 32'(lat), 32'(3 * NW));
    chk({tag, "_busy"}, 32'(bcnt), 32'(3 * NW));
  endtask

  initial begin
    rst_n = 1'b0;
    ram_in_we = 1'b0;
    ram_in_addr_wr = '0;
    ram_in_data_wr = '0;
    ram_out_addr_rd = '0;
    start_in = 1'b1;
    step();
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    rst_n = 1'b1;
    start_in = 1'b0;
    step();
    chk("idle_busy", 32'(busy_out), 32'd0);

    // Basic run
    for (int i = 0; i < NW; i++) wr(i, 16'h0000);
    wr(0, 16'hA55A);
    wr(15, 16'h1234);
    run("basic");
    chk("basic_done", 32'(done_out), 32'd1);
    chk_bytes("basic");
    step();
    chk("done_hold", 32'(done_out), 32'd1);

    // Full pattern
    for (int i = 0; i < NW; i++) wr(i, {8'(i + 8'h80), 8'(i)});
    run("pat");
    chk_bytes("pat");

    // Start and host writes while busy
    for (int i = 0; i < NW; i++) wr(i, 16'($urandom));
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int c = 1; c < 10; c++) step();
    start_in = 1'b1;
    wr(3, 16'hFFFF);
    start_in = 1'b0;
    wait_done(lat, bcnt);
    chk("busywr_lat", 32'(lat + 10), 32'(3 * NW));
    chk_bytes("busywr1");
    run("busywr2");
    chk_bytes("busywr2");

    // Reset mid-run
    for (int i = 0; i < NW; i++) wr(i, 16'($urandom));
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int c = 1; c < 20; c++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy_out), 32'd0);
    chk("mid_rst_done", 32'(done_out), 32'd0);
    step();
    chk("mid_rst_idle", 32'(busy_out), 32'd0);
    run("restart");
    chk_bytes("restart");

    // Continuous start
    for (int i = 0; i < NW; i++) wr(i, 16'($urandom));
    start_in = 1'b1;
    step();
    wait_done(lat, bcnt);
    chk("cont1_lat", 32'(lat), 32'(3 * NW));
    step();
    chk("cont_gap_done", 32'(done_out), 32'd0);
    chk("cont_gap_busy", 32'(busy_out), 32'd1);
    start_in = 1'b0;
    wait_done(lat, bcnt);
    chk("cont2_lat", 32'(lat), 32'(3 * NW));
    chk_bytes("cont2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/word_unpack_fsm.md
Name: word_unpack_fsm

Overview:
- Reverse data path of the byte-pack engine.
- Reads 16-bit words from an internal 16x16 input RAM and splits each word into two bytes.
- Writes the bytes into an internal 32x8 output RAM.
- Both RAMs are instances of ram_dp_async_read. A host loads words through the input RAM write port, pulses start_in, waits for done_out, then reads bytes back through the output RAM read port.

Parameters:
- N_WORDS, 16, number of 16-bit words processed per run; power of two, at least 2.
- WAW, 4, word address width, equal to log2(N_WORDS).
- BAW, 5, byte address width, equal to WAW+1.

Ports:
- clk  input  1  single clock for the FSM and both RAMs.
- rst_n  input  1  reset; synchronous, active-low.
- ram_in_we  input  1  host write enable, input word RAM.
- ram_in_addr_wr  input  WAW  host word write address.
- ram_in_data_wr  input  16  host word write data.
- ram_out_addr_rd  input  BAW  host byte read address.
- ram_out_data_rd  output  8  host byte read data; asynchronous read.
- start_in  input  1  start request, sampled only in IDLE.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  registered completion flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, word_ptr=0, word_buf=16'h0000, done_out=0, busy_out=0.
  - RAM contents are not cleared.
- States: IDLE, READ_WORD, WRITE_LO, WRITE_HI.
- IDLE:
  - If start_in=1: clear done_out, word_ptr<=0, go to READ_WORD.
  - Otherwise stay in IDLE.
- READ_WORD:
  - Input RAM read address = word_ptr.
  - word_buf <= input RAM read data.
  - Go to WRITE_LO.
- WRITE_LO:
  - Output RAM we=1, addr={word_ptr,1'b0}, data=word_buf[7:0].
  - Go to WRITE_HI.
- WRITE_HI:
  - Output RAM we=1, addr={word_ptr,1'b1}, data=word_buf[15:8].
  - If word_ptr==N_WORDS-1: done_out<=1, go to IDLE.
  - Otherwise word_ptr<=word_ptr+1, go to READ_WORD.
- Output RAM we is 0 in IDLE and READ_WORD. The RAM write port is driven only by the FSM.
- Latency:
  - 3 cycles per word.
  - done_out is high starting 3*N_WORDS edges after the edge that samples start_in (48 for the default).
  - busy_out is high for exactly 3*N_WORDS cycles.
- done_out:
  - Holds 1 in IDLE until start_in is sampled again.
  - start_in=1 held continuously causes back-to-back runs. done_out is high for exactly one cycle between runs.
- start_in while busy: ignored. No restart, no pointer change.
- Host writes while busy: ram_in_we is gated with !busy_out, so writes are dropped and the input RAM is unchanged.
- Host reads while busy: allowed; return current output RAM contents, which may be partially updated.
- Pointer wrap:
  - word_ptr never wraps during a run; the terminal test is word_ptr==N_WORDS-1.
  - Byte address {word_ptr,1} on the last word is 2*N_WORDS-1 (31 for the default).
- Reset mid-run: returns to IDLE with done_out=0 at the reset edge. Bytes already written stay. The next start performs a full run from word 0.
- Simultaneous rst_n=0 and start_in=1: reset wins.

Optional Feature:
- Macro: WORD_UNPACK_BIG_ENDIAN_EN.
- Defined: WRITE_LO writes word_buf[15:8] to the even address and WRITE_HI writes word_buf[7:0] to the odd address (big-endian byte order).
- Undefined: little-endian as specified above (low byte at the even address).
- Timing, handshake and done_out are identical in both builds.

Test Plan:
- Basic run:
  - Load word[0]=16'hA55A and word[15]=16'h1234 (others 0), then pulse start_in for one cycle.
  - busy_out is high for 48 cycles and done_out rises on the 48th edge after start.
  - Bytes: out[0]=8'h5A, out[1]=8'hA5, out[30]=8'h34, out[31]=8'h12.
- Full pattern: load word[i]={i+8'h80, i}. After done, out[2i]=i and out[2i+1]=i+8'h80 for all i in 0..15.
- Start and host writes while busy:
  - At cycle 10 of a run, pulse start_in and write word[3]=16'hFFFF.
  - The run still completes at edge 48. word[3] keeps its old value; confirm with a second run that out[6]/out[7] are unchanged.
- Reset mid-run:
  - Assert rst_n=0 for one edge at cycle 20: state IDLE, busy_out=0, done_out=0.
  - Restart: done_out at edge 48 and all 32 bytes correct.
- Continuous start: hold start_in=1 across two runs. done_out is high for exactly one cycle between runs; second-run bytes are correct.
- Big-endian build (WORD_UNPACK_BIG_ENDIAN_EN defined): word[0]=16'hA55A gives out[0]=8'hA5 and out[1]=8'h5A; same 48-cycle latency.
